// File: rtl/mc_pi_accumulator.sv
// Monte Carlo pi accumulator: pairs random words into (x,y) points and counts quarter-circle hits.
// Build option MC_PI_LIVE_EN: hits/total track the running counters instead of updating only on DONE.
module mc_pi_accumulator #(
    parameter int W     = 32,
    parameter int Q     = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     rnd_data,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] total
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] pairs_issued;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] pt_cnt;
    logic             phase_y;
    logic [Q-1:0]     x_coord;
    logic             sq_valid;
    logic [2*Q-1:0]   x_sq;
    logic [2*Q-1:0]   y_sq;
    logic [2*Q:0]     sq_sum;
    logic             point_hit;
    logic [Q-1:0]     word_top;
    logic [2*Q-1:0]   x_ext;
    logic [2*Q-1:0]   y_ext;
    logic             xfer;
    logic             y_xfer;
    logic             last_pair;
    logic             start_ok;
    logic             unused_low;

    assign word_top   = rnd_data[W-1 -: Q];
    assign unused_low = ^rnd_data[W-Q-1:0];
    assign x_ext      = {{Q{1'b0}}, x_coord};
    assign y_ext      = {{Q{1'b0}}, word_top};
    assign xfer       = rnd_valid & rnd_ready;
    assign y_xfer     = xfer & phase_y;
    assign last_pair  = y_xfer && ((pairs_issued + CNT_W'(1)) == target);
    assign start_ok   = (state == IDLE) && start;
    assign sq_sum     = {1'b0, x_sq} + {1'b0, y_sq};
    assign point_hit  = (sq_sum < {1'b1, {(2*Q){1'b0}}});

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_samples == '0) ? DONE : RUN;
            RUN:     if (last_pair) state_next = DRAIN;
            DRAIN:   if (!sq_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The square stage holds the only in-flight pair; the accumulate stage folds into the counters on the same edge it empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rnd_ready    <= 1'b0;
            target       <= '0;
            pairs_issued <= '0;
            phase_y      <= 1'b0;
            x_coord      <= '0;
            sq_valid     <= 1'b0;
            x_sq         <= '0;
            y_sq         <= '0;
            hit_cnt      <= '0;
            pt_cnt       <= '0;
        end else begin
            state     <= state_next;
            rnd_ready <= (state_next == RUN);
            sq_valid  <= y_xfer;
            if (start_ok) begin
                target       <= num_samples;
                pairs_issued <= '0;
                phase_y      <= 1'b0;
                hit_cnt      <= '0;
                pt_cnt       <= '0;
            end else begin
                if (xfer) begin
                    phase_y <= ~phase_y;
                    if (!phase_y) x_coord <= word_top;
                end
                if (y_xfer) begin
                    pairs_issued <= pairs_issued + CNT_W'(1);
                    x_sq         <= x_ext * x_ext;
                    y_sq         <= y_ext * y_ext;
                end
                if (sq_valid) begin
                    hit_cnt <= hit_cnt + CNT_W'(point_hit);
                    pt_cnt  <= pt_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits  <= '0;
            total <= '0;
        end
`ifdef MC_PI_LIVE_EN
        else begin
            hits  <= hit_cnt;
            total <= pt_cnt;
        end
`else
        // A zero-length run jumps straight from IDLE, before the cleared counters are visible.
        else if (state_next == DONE) begin
            hits  <= (state == IDLE) ? '0 : hit_cnt;
            total <= (state == IDLE) ? '0 : pt_cnt;
        end
`endif
    end

endmodule

// File: tb/tb_mc_pi_accumulator.sv
// Scoreboard bench for mc_pi_accumulator: expected hit/total results are queued when a run's
// words are scheduled and popped when the DUT signals done.
module tb_mc_pi_accumulator;

    localparam int W     = 32;
    localparam int Q     = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [CNT_W-1:0] num_samples;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] total;

    mc_pi_accumulator #(.W(W), .Q(Q), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .num_samples(num_samples),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .hits       (hits),
        .total      (total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] hits;
        logic [CNT_W-1:0] total;
    } result_t;

    result_t      exp_q[$];
    logic [W-1:0] word_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    int               obs_done_cyc;
    int               obs_last_y_cyc;
    int               obs_extra;
    logic             obs_ready_after;
    logic             obs_busy_at_done;
    logic             obs_ever_ready;
    logic [CNT_W-1:0] obs_hits;
    logic [CNT_W-1:0] obs_total;

    function automatic bit model_hit(input logic [W-1:0] xw, input logic [W-1:0] yw);
        longint unsigned xv;
        longint unsigned yv;
        xv = 64'(xw[W-1:W-Q]);
        yv = 64'(yw[W-1:W-Q]);
        return (xv * xv + yv * yv) < (64'd1 << (2 * Q));
    endfunction

    function automatic void push_expected(input int n);
        result_t r;
        int      h = 0;
        for (int i = 0; i < n; i++) h += int'(model_hit(word_q[2*i], word_q[2*i+1]));
        r.hits  = CNT_W'(h);
        r.total = CNT_W'(n);
        exp_q.push_back(r);
    endfunction

    // Drives one run from word_q and records what the DUT did; checking is left to each test.
    task automatic feed_run(input int n, input int gap_pct, input bit pulse_mid);
        int idx = 0;
        int cyc = 0;
        bit fire;
        obs_done_cyc     = -1;
        obs_last_y_cyc   = -1;
        obs_extra        = 0;
        obs_ready_after  = 1'b1;
        obs_busy_at_done = 1'b1;
        obs_ever_ready   = 1'b0;
        obs_hits         = '1;
        obs_total        = '1;
        push_expected(n);
        @(negedge clk);
        num_samples = CNT_W'(n);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        num_samples = $urandom;
        forever begin
            if (done) begin
                obs_done_cyc     = cyc;
                obs_busy_at_done = busy;
                obs_hits         = hits;
                obs_total        = total;
                break;
            end
            if (cyc >= 500) break;
            if (rnd_ready) obs_ever_ready = 1'b1;
            if (obs_last_y_cyc >= 0 && cyc == obs_last_y_cyc + 1) obs_ready_after = rnd_ready;
            start = pulse_mid && (cyc == 3);
            if (start) num_samples = CNT_W'(7);
            if (idx < 2 * n) begin
                rnd_valid = (int'($urandom_range(99)) >= gap_pct);
                if (gap_pct > 0 && (idx % 2) == 1 && (cyc % 3) == 0) rnd_valid = 1'b0;
                rnd_data = word_q[idx];
            end else begin
                rnd_valid = 1'b1;
                rnd_data  = $urandom;
            end
            fire = rnd_valid && rnd_ready;
            if (fire) begin
                if (idx < 2 * n) begin
                    idx++;
                    if (idx == 2 * n) obs_last_y_cyc = cyc;
                end else begin
                    obs_extra++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        rnd_valid = 1'b0;
        word_q.delete();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        rnd_valid   = 1'b0;
        rnd_data    = '0;
        num_samples = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rnd_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 0", rnd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (hits !== '0) begin n_bad++; $display("[TB] FAIL reset_hits: got %0d want 0", hits); end
        n_cmp++; if (total !== '0) begin n_bad++; $display("[TB] FAIL reset_total: got %0d want 0", total); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_hit();
        result_t e;
        word_q = '{32'h0000_1234, 32'h0000_ABCD};
        feed_run(1, 0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (obs_done_cyc !== obs_last_y_cyc + 3) begin n_bad++; $display("[TB] FAIL hit1_latency: done at %0d want %0d", obs_done_cyc, obs_last_y_cyc + 3); end
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL hit1_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL hit1_total: got %0d want %0d", obs_total, e.total); end
        n_cmp++; if (obs_busy_at_done !== 1'b0) begin n_bad++; $display("[TB] FAIL hit1_busy: got %b want 0", obs_busy_at_done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL hit1_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_single_miss();
        result_t e;
        word_q = '{32'hFFFF_0000, 32'hFFFF_FFFF};
        feed_run(1, 0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL miss_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL miss_total: got %0d want %0d", obs_total, e.total); end
        word_q = '{32'hFFFF_0000, 32'h0000_0000};
        feed_run(1, 0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL edge_hit_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_done_cyc !== obs_last_y_cyc + 3) begin n_bad++; $display("[TB] FAIL edge_hit_latency: done at %0d want %0d", obs_done_cyc, obs_last_y_cyc + 3); end
    endtask

    task automatic test_boundaries();
        result_t e;
        word_q = '{32'h0000_FFFF, 32'h0000_1111, 32'hFFFF_0000, 32'hFFFF_ABCD,
                   32'hB504_0000, 32'hB504_FFFF, 32'hB505_0000, 32'hB505_0001};
        feed_run(4, 0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL bound_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_hits !== CNT_W'(2)) begin n_bad++; $display("[TB] FAIL bound_hits_abs: got %0d want 2", obs_hits); end
        n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL bound_total: got %0d want %0d", obs_total, e.total); end
        n_cmp++; if (obs_extra !== 0) begin n_bad++; $display("[TB] FAIL bound_extra_words: got %0d want 0", obs_extra); end
    endtask

    task automatic test_reset_mid_run();
        result_t e;
        int      got = 0;
        int      cyc = 0;
        @(negedge clk);
        num_samples = CNT_W'(2);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (got < 3 && cyc < 50) begin
            rnd_valid = 1'b1;
            rnd_data  = (got == 2) ? 32'h0000_0000 : 32'h4000_0000;
            if (rnd_ready) got++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (got !== 3) begin n_bad++; $display("[TB] FAIL rstmid_words: got %0d want 3", got); end
        rnd_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({rnd_ready, busy, done} !== 3'b000) begin n_bad++; $display("[TB] FAIL rstmid_ctrl: got %b want 000", {rnd_ready, busy, done}); end
        n_cmp++; if (hits !== '0) begin n_bad++; $display("[TB] FAIL rstmid_hits: got %0d want 0", hits); end
        n_cmp++; if (total !== '0) begin n_bad++; $display("[TB] FAIL rstmid_total: got %0d want 0", total); end
        @(negedge clk);
        rst = 1'b0;
        word_q = '{32'hFFFF_1111, 32'h8000_2222};
        feed_run(1, 0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL rstmid_rerun_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL rstmid_rerun_total: got %0d want %0d", obs_total, e.total); end
    endtask

    task automatic test_gaps();
        result_t e;
        for (int i = 0; i < 6; i++) word_q.push_back($urandom);
        feed_run(3, 50, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL gaps_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL gaps_total: got %0d want %0d", obs_total, e.total); end
        n_cmp++; if (obs_ready_after !== 1'b0) begin n_bad++; $display("[TB] FAIL gaps_ready_drop: got %b want 0", obs_ready_after); end
        n_cmp++; if (obs_extra !== 0) begin n_bad++; $display("[TB] FAIL gaps_extra_words: got %0d want 0", obs_extra); end
        n_cmp++; if (obs_done_cyc !== obs_last_y_cyc + 3) begin n_bad++; $display("[TB] FAIL gaps_latency: done at %0d want %0d", obs_done_cyc, obs_last_y_cyc + 3); end
    endtask

    task automatic test_zero();
        result_t e;
        feed_run(0, 0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (obs_done_cyc !== 0) begin n_bad++; $display("[TB] FAIL zero_done_cycle: got %0d want 0", obs_done_cyc); end
        n_cmp++; if (obs_ever_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_ready: got %b want 0", obs_ever_ready); end
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL zero_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL zero_total: got %0d want %0d", obs_total, e.total); end
        n_cmp++; if (obs_extra !== 0) begin n_bad++; $display("[TB] FAIL zero_extra_words: got %0d want 0", obs_extra); end
    endtask

    task automatic test_start_while_busy();
        result_t e;
        word_q = '{32'h1000_0000, 32'h2000_0000, 32'hF000_0000, 32'hF000_0000};
        feed_run(2, 0, 1'b1);
        e = exp_q.pop_front();
        n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL busy_start_hits: got %0d want %0d", obs_hits, e.hits); end
        n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL busy_start_total: got %0d want %0d", obs_total, e.total); end
        n_cmp++; if (obs_done_cyc !== obs_last_y_cyc + 3) begin n_bad++; $display("[TB] FAIL busy_start_latency: done at %0d want %0d", obs_done_cyc, obs_last_y_cyc + 3); end
    endtask

    task automatic test_back_to_back();
        result_t e;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) word_q.push_back($urandom);
            feed_run(5, 20, 1'b0);
            e = exp_q.pop_front();
            n_cmp++; if (obs_hits !== e.hits) begin n_bad++; $display("[TB] FAIL b2b_hits run %0d: got %0d want %0d", r, obs_hits, e.hits); end
            n_cmp++; if (obs_total !== e.total) begin n_bad++; $display("[TB] FAIL b2b_total run %0d: got %0d want %0d", r, obs_total, e.total); end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_single_miss();
        test_boundaries();
        test_reset_mid_run();
        test_gaps();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
